// File: rtl/hci_pkg.sv
// ---------------------------------------------------------------------------
// hci_pkg
// Shared widths and types for the HCI / TTI datapath blocks.
//   TtiRxDataWidth        width of one packed RX data word
//   TtiRxDescDataWidth    width of one RX descriptor
//   tti_rx_desc_t         RX descriptor layout
//   tti_rx_packer_state_e FSM states of tti_rx_packer
// ---------------------------------------------------------------------------
package hci_pkg;

    localparam int unsigned TtiRxDataWidth     = 32;
    localparam int unsigned TtiRxDescDataWidth = 32;

    // Largest byte count the descriptor length field can report.
    localparam logic [15:0] TtiRxLenMax = 16'hFFFF;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FLUSH   = 2'd1,
        DESC    = 2'd2
    } tti_rx_packer_state_e;

    typedef struct packed {
        logic [13:0] reserved;
        logic        len_ovf;
        logic        err;
        logic [15:0] data_length;
    } tti_rx_desc_t;

    function automatic tti_rx_desc_t tti_rx_desc_pack(input logic [15:0] len,
                                                      input logic        err,
                                                      input logic        ovf);
        tti_rx_desc_t d;
        d.reserved    = '0;
        d.len_ovf     = ovf;
        d.err         = err;
        d.data_length = len;
        return d;
    endfunction

endpackage

// File: rtl/tti_rx_packer.sv
// ---------------------------------------------------------------------------
// tti_rx_packer
// Packs the received private-write byte stream little-endian into 32-bit
// words for the TTI RX data queue and, at end of transfer, emits one RX
// descriptor holding byte count, error and length-overflow flags.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   in_valid_i/in_ready_o  byte-stream input beat handshake
//   in_byte_i            data byte (ignored on an end beat)
//   in_end_i             end-of-transfer beat, carries no data
//   in_err_i             transfer error, sampled on the end beat
//   rx_data_*            packed word output to the RX data queue
//   rx_desc_*            descriptor output to the RX descriptor queue
//   dbg_state_o          current FSM state, for observation only
//
// Handshakes: every interface transfers exactly on a clock edge where
// valid && ready are both high. A producer never drops valid, nor changes
// its payload, until that transfer has happened (reset excepted).
// ---------------------------------------------------------------------------
module tti_rx_packer
    import hci_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [7:0]                    in_byte_i,
    input  logic                          in_end_i,
    input  logic                          in_err_i,
    output logic                          rx_data_valid_o,
    input  logic                          rx_data_ready_i,
    output logic [TtiRxDataWidth-1:0]     rx_data_o,
    output logic                          rx_desc_valid_o,
    input  logic                          rx_desc_ready_i,
    output logic [TtiRxDescDataWidth-1:0] rx_desc_o,
    output tti_rx_packer_state_e          dbg_state_o
);

    tti_rx_packer_state_e        r_state;
    tti_rx_packer_state_e        w_state_next;

    logic [TtiRxDataWidth-1:0]   r_acc;
    logic [1:0]                  r_lane;
    logic [15:0]                 r_len;
    logic                        r_err;
    logic                        r_ovf;
    logic [TtiRxDataWidth-1:0]   r_data;
    logic                        r_data_valid;

    logic                        w_in_ready;
    logic                        w_desc_valid;
    logic                        w_data_beat;
    logic                        w_end_beat;
    logic                        w_data_pop;
    logic                        w_desc_pop;
    tti_rx_desc_t                w_desc;

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_desc_valid = 1'b0;
        case (r_state)
            COLLECT: begin
                // A pending word blocks input, which is also what keeps an
                // end beat from overtaking an unaccepted full word.
                w_in_ready = !r_data_valid;
                if (in_valid_i && w_in_ready && in_end_i) begin
                    w_state_next = (r_lane != 2'd0) ? FLUSH : DESC;
                end
            end
            FLUSH: begin
                if (r_data_valid && rx_data_ready_i) begin
                    w_state_next = DESC;
                end
            end
            DESC: begin
                w_desc_valid = 1'b1;
                if (rx_desc_ready_i) begin
                    w_state_next = COLLECT;
                end
            end
            default: w_state_next = COLLECT;
        endcase
    end

    assign w_data_beat = in_valid_i && w_in_ready && !in_end_i;
    assign w_end_beat  = in_valid_i && w_in_ready && in_end_i;
    assign w_data_pop  = r_data_valid && rx_data_ready_i;
    assign w_desc_pop  = w_desc_valid && rx_desc_ready_i;

    // ---------------- byte-lane datapath ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_acc        <= '0;
            r_lane       <= 2'd0;
            r_len        <= 16'd0;
            r_err        <= 1'b0;
            r_ovf        <= 1'b0;
            r_data       <= '0;
            r_data_valid <= 1'b0;
        end else begin
            if (w_data_pop) begin
                r_data_valid <= 1'b0;
            end

            if (w_data_beat) begin
                if (r_len != TtiRxLenMax) begin
                    r_len <= r_len + 16'd1;
                end
                // Flag set on the byte that brings the count to the maximum.
                if (r_len >= TtiRxLenMax - 16'd1) begin
                    r_ovf <= 1'b1;
                end
                if (r_lane == 2'd3) begin
                    // Last lane goes straight to the output register; the
                    // accumulator restarts empty for the next word.
                    r_data       <= {in_byte_i, r_acc[23:0]};
                    r_data_valid <= 1'b1;
                    r_acc        <= '0;
                end else begin
                    r_acc[{r_lane, 3'b000} +: 8] <= in_byte_i;
                end
                r_lane <= r_lane + 2'd1;
            end

            if (w_end_beat) begin
                r_err <= in_err_i;
                if (r_lane != 2'd0) begin
                    // Unused upper lanes are already zero in the accumulator.
                    r_data       <= r_acc;
                    r_data_valid <= 1'b1;
                    r_acc        <= '0;
                    r_lane       <= 2'd0;
                end
            end

            if (w_desc_pop) begin
                r_len  <= 16'd0;
                r_lane <= 2'd0;
                r_err  <= 1'b0;
                r_ovf  <= 1'b0;
            end
        end
    end

    assign w_desc = tti_rx_desc_pack(r_len, r_err, r_ovf);

    assign in_ready_o      = w_in_ready;
    assign rx_data_valid_o = r_data_valid;
    assign rx_data_o       = r_data;
    assign rx_desc_valid_o = w_desc_valid;
    assign rx_desc_o       = w_desc_valid ? w_desc : '0;
    assign dbg_state_o     = r_state;

endmodule

// File: tb/tb_tti_rx_packer.sv
module tb_tti_rx_packer;
  import hci_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  initial forever #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_byte = 8'h00;
  logic        in_end = 1'b0;
  logic        in_err = 1'b0;
  logic        rx_data_valid;
  logic        rx_data_ready = 1'b1;
  logic [31:0] rx_data;
  logic        rx_desc_valid;
  logic        rx_desc_ready = 1'b1;
  logic [31:0] rx_desc;
  tti_rx_packer_state_e dbg_state;

  tti_rx_packer dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .in_byte_i       (in_byte),
    .in_end_i        (in_end),
    .in_err_i        (in_err),
    .rx_data_valid_o (rx_data_valid),
    .rx_data_ready_i (rx_data_ready),
    .rx_data_o       (rx_data),
    .rx_desc_valid_o (rx_desc_valid),
    .rx_desc_ready_i (rx_desc_ready),
    .rx_desc_o       (rx_desc),
    .dbg_state_o     (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail = 0;
  int words_seen = 0;
  logic [31:0] exp_data_q[$];
  logic [31:0] exp_desc_q[$];
  logic [7:0]  tx_q[$];
  int d_mode = 1;  // 0 = ready low, 1 = ready high, 2 = random
  int q_mode = 1;

  typedef struct {
    int          nbytes;
    logic        err;
    logic [7:0]  first;
    logic [7:0]  step;
    logic [31:0] exp_desc;
    int          exp_words;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // ---------------- sink readiness ----------------
  initial forever begin
    @(posedge clk);
    #1;
    rx_data_ready = (d_mode == 2) ? 1'($urandom_range(0, 1)) : (d_mode == 1);
    rx_desc_ready = (q_mode == 2) ? 1'($urandom_range(0, 1)) : (q_mode == 1);
  end

  // ---------------- output monitor ----------------
  initial begin
    logic stall_d, stall_q;
    logic [31:0] held_d, held_q;
    stall_d = 1'b0;
    stall_q = 1'b0;
    held_d = '0;
    held_q = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_d = 1'b0;
        stall_q = 1'b0;
      end else begin
        if (stall_d) begin
          chk("data_valid_held", 32'(rx_data_valid), 32'd1);
          chk("data_stable", rx_data, held_d);
        end
        if (stall_q) begin
          chk("desc_valid_held", 32'(rx_desc_valid), 32'd1);
          chk("desc_stable", rx_desc, held_q);
        end
        if (rx_data_valid && rx_data_ready) begin
          words_seen++;
          if (exp_data_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL data_unexpected: got %08h expected no word", rx_data);
          end else begin
            chk("data_word", rx_data, exp_data_q.pop_front());
          end
        end
        if (rx_desc_valid && rx_desc_ready) begin
          chk("desc_after_all_words", 32'(exp_data_q.size()), 32'd0);
          if (exp_desc_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL desc_unexpected: got %08h expected no descriptor", rx_desc);
          end else begin
            chk("desc", rx_desc, exp_desc_q.pop_front());
          end
        end
        stall_d = rx_data_valid && !rx_data_ready;
        held_d  = rx_data;
        stall_q = rx_desc_valid && !rx_desc_ready;
        held_q  = rx_desc;
      end
    end
  end

  // ---------------- reference model ----------------
  // Words: tx bytes grouped by four, first byte lowest, short tail zero-padded.
  task automatic model_words();
    int n;
    logic [31:0] w;
    n = tx_q.size();
    for (int i = 0; i < n; i += 4) begin
      w = '0;
      for (int k = 0; k < 4; k++) begin
        if (i + k < n) w = w | (32'(tx_q[i + k]) << (8 * k));
      end
      exp_data_q.push_back(w);
    end
  endtask

  task automatic model_desc(input logic err);
    int n;
    logic [15:0] len;
    logic ovf;
    n = tx_q.size();
    len = (n > 65535) ? 16'hFFFF : 16'(n);
    ovf = (n >= 65535);
    exp_desc_q.push_back({14'd0, ovf, err, len});
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [7:0] b, input logic e, input logic err);
    int t;
    in_valid = 1'b1;
    in_byte  = b;
    in_end   = e;
    in_err   = err;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 200) begin
        n_tests++;
        n_fail++;
        $display("FAIL in_ready_timeout: got 0 expected 1 within 200 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_end   = 1'b0;
    in_err   = 1'b0;
  endtask

  task automatic send_transfer(input logic err);
    foreach (tx_q[i]) send_beat(tx_q[i], 1'b0, 1'b0);
    send_beat(8'h00, 1'b1, err);
    idle();
  endtask

  task automatic drain(input int limit);
    int t;
    t = 0;
    while ((exp_data_q.size() != 0 || exp_desc_q.size() != 0) && t < limit) begin
      @(posedge clk);
      t++;
    end
    chk("drain_pending", 32'(exp_data_q.size() + exp_desc_q.size()), 32'd0);
    exp_data_q.delete();
    exp_desc_q.delete();
  endtask

  task automatic wait_sig(input string name, input int which);
    int t;
    t = 0;
    while (((which == 0) ? !rx_data_valid : !rx_desc_valid) && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk(name, 32'((which == 0) ? rx_data_valid : rx_desc_valid), 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int w0;
    logic [7:0] b;

    tbl[0] = '{5,  1'b0, 8'h11, 8'h11, 32'h0000_0005, 2};
    tbl[1] = '{0,  1'b1, 8'h00, 8'h00, 32'h0001_0000, 0};
    tbl[2] = '{4,  1'b0, 8'hA0, 8'h01, 32'h0000_0004, 1};
    tbl[3] = '{3,  1'b1, 8'h01, 8'h01, 32'h0001_0003, 1};
    tbl[4] = '{1,  1'b0, 8'hAB, 8'h00, 32'h0000_0001, 1};
    tbl[5] = '{7,  1'b0, 8'h10, 8'h10, 32'h0000_0007, 2};
    tbl[6] = '{12, 1'b1, 8'hF0, 8'h03, 32'h0001_000C, 3};

    // reset values
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_data_valid", 32'(rx_data_valid), 32'd0);
    chk("rst_data", rx_data, 32'd0);
    chk("rst_desc_valid", 32'(rx_desc_valid), 32'd0);
    chk("rst_desc", rx_desc, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(COLLECT));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // table-driven transfers, both sinks always ready
    foreach (tbl[v]) begin
      tx_q.delete();
      for (int i = 0; i < tbl[v].nbytes; i++) tx_q.push_back(tbl[v].first + 8'(i) * tbl[v].step);
      model_words();
      exp_desc_q.push_back(tbl[v].exp_desc);
      w0 = words_seen;
      send_transfer(tbl[v].err);
      drain(100);
      chk($sformatf("tbl%0d_words", v), 32'(words_seen - w0), 32'(tbl[v].exp_words));
    end

    // data back-pressure after the first word
    d_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    exp_data_q.push_back(32'h0403_0201);
    exp_data_q.push_back(32'h0807_0605);
    exp_desc_q.push_back(32'h0000_0008);
    for (int i = 1; i <= 4; i++) send_beat(8'(i), 1'b0, 1'b0);
    in_valid = 1'b1;
    in_byte  = 8'h05;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_data_hold", rx_data, 32'h0403_0201);
      chk("bp_no_desc", 32'(rx_desc_valid), 32'd0);
    end
    d_mode = 1;
    for (int i = 5; i <= 8; i++) send_beat(8'(i), 1'b0, 1'b0);
    send_beat(8'h00, 1'b1, 1'b0);
    idle();
    drain(100);

    // descriptor back-pressure, then length restarts from zero
    q_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    exp_data_q.push_back(32'h0003_0201);
    exp_desc_q.push_back(32'h0000_0003);
    tx_q.delete();
    tx_q = '{8'h01, 8'h02, 8'h03};
    send_transfer(1'b0);
    wait_sig("desc_stall_valid", 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("desc_stall_value", rx_desc, 32'h0000_0003);
      chk("desc_stall_in_ready", 32'(in_ready), 32'd0);
    end
    q_mode = 1;
    drain(50);
    exp_data_q.push_back(32'h0000_C2C1);
    exp_desc_q.push_back(32'h0000_0002);
    tx_q = '{8'hC1, 8'hC2};
    send_transfer(1'b0);
    drain(50);

    // reset while the partial word waits in FLUSH
    d_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    send_beat(8'h99, 1'b0, 1'b0);
    send_beat(8'h00, 1'b1, 1'b0);
    idle();
    wait_sig("flush_valid", 0);
    chk("flush_state", 32'(dbg_state), 32'(FLUSH));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_data_valid", 32'(rx_data_valid), 32'd0);
    chk("arst_data", rx_data, 32'd0);
    chk("arst_desc_valid", 32'(rx_desc_valid), 32'd0);
    chk("arst_desc", rx_desc, 32'd0);
    d_mode = 1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_data_q.push_back(32'h0000_00AB);
    exp_desc_q.push_back(32'h0000_0001);
    tx_q = '{8'hAB};
    send_transfer(1'b0);
    drain(50);

    // randomized transfers with random sink readiness
    d_mode = 2;
    q_mode = 2;
    for (int r = 0; r < 30; r++) begin
      logic err;
      tx_q.delete();
      for (int i = 0; i < $urandom_range(0, 13); i++) tx_q.push_back(8'($urandom_range(0, 255)));
      err = 1'($urandom_range(0, 1));
      model_words();
      model_desc(err);
      w0 = words_seen;
      send_transfer(err);
      drain(400);
      chk("rand_words", 32'(words_seen - w0), 32'((tx_q.size() + 3) / 4));
    end

    // length saturation
    d_mode = 1;
    q_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    tx_q.delete();
    for (int i = 0; i < 65537; i++) begin
      b = 8'(i);
      tx_q.push_back(b);
    end
    model_words();
    exp_desc_q.push_back(32'h0002_FFFF);
    w0 = words_seen;
    send_transfer(1'b0);
    drain(200);
    chk("sat_words", 32'(words_seen - w0), 32'd16385);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tti_rx_packer.md
# tti_rx_packer

Target-side receive packer for the Target Transaction Interface. Accepts the byte stream produced by the I3C target bus FSM during a private write, packs bytes little-endian into TtiRxDataWidth (32-bit) words for the TTI RX data queue, and, at end of transfer, emits one TtiRxDescDataWidth (32-bit) RX descriptor carrying byte count and status. It is the receive-direction counterpart of the TX path, which unpacks TX data words into bytes.

## Interface
Parameters:
- none; widths come from hci_pkg (TtiRxDataWidth = 32, TtiRxDescDataWidth = 32).

Ports:
- clk_i  in  1  single clock
- rst_ni  in  1  reset; asynchronous, active-low
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  input beat accepted when in_valid_i && in_ready_o
- in_byte_i  in  8  received data byte; ignored when in_end_i = 1
- in_end_i  in  1  beat marks end of transfer and carries no data
- in_err_i  in  1  transfer ended with error (parity/abort); sampled only on an end beat
- rx_data_valid_o  out  1  packed word available
- rx_data_ready_i  in  1  RX data queue accepts word
- rx_data_o  out  32  packed word; first byte received at [7:0]
- rx_desc_valid_o  out  1  descriptor available
- rx_desc_ready_i  in  1  RX descriptor queue accepts descriptor
- rx_desc_o  out  32  descriptor: [15:0] length in bytes, [16] err, [17] length overflow, [31:18] zero

## Operation
- States: COLLECT, FLUSH, DESC. Reset state: COLLECT.
- COLLECT: in_ready_o = !rx_data_valid_o.
  - Data beat: store the byte in lane byte_cnt[1:0] of the accumulation word and increment the lane.
  - Length: 16-bit counter, incremented per data byte, saturates at 0xFFFF. Reaching saturation sets the overflow flag; bytes keep being packed.
  - 4th lane filled: accumulation word is copied to the output register, rx_data_valid_o = 1, lane returns to 0, accumulation word cleared to zero.
- End beat in COLLECT:
  - Latch in_err_i.
  - Lane != 0: go to FLUSH. The partial word goes to the output register with unused upper bytes zero.
  - Lane == 0: go to DESC.
- FLUSH: in_ready_o = 0. When the partial word handshake completes (rx_data_valid_o && rx_data_ready_i), go to DESC.
- DESC:
  - in_ready_o = 0, rx_desc_valid_o = 1, rx_desc_o built from the length counter and flags.
  - On rx_desc_ready_i: return to COLLECT and clear the length counter, lane, err flag and overflow flag.
- Ordering: a descriptor is never presented before every data word of its transfer has been accepted. Because in_ready_o = !rx_data_valid_o, an end beat cannot be accepted while a full word is still pending, so this ordering holds.
- Zero-length transfer (end beat with no prior bytes): no data word; descriptor with length 0.
- Reset mid-operation: all state is discarded; the partial word and pending descriptor are lost and no output handshake completes.

## Timing
- Reset values: in_ready_o = 1, rx_data_valid_o = 0, rx_data_o = 0, rx_desc_valid_o = 0, rx_desc_o = 0.
- rx_data_valid_o rises the cycle after the 4th byte (or the end beat, when lane != 0) is accepted.
- rx_desc_valid_o rises:
  - the cycle after the end beat, when lane == 0;
  - the cycle after the final data handshake, when coming from FLUSH.
- Outputs are registered. rx_data_o and rx_desc_o are stable while their valid is high and ready is low.
- Valid never drops without a handshake, except on reset.
- A word pops in the same cycle its ready is seen. in_ready_o rises the cycle after the pop.
- Peak throughput: 4 bytes per 5 cycles.
- Simultaneous rx_data_ready_i and in_valid_i in COLLECT: the pop completes and the input beat is not accepted that cycle.

## Structure
- hci_pkg gains typedef tti_rx_desc_t: a packed struct of reserved[31:18], len_ovf, err, data_length[15:0], sized to TtiRxDescDataWidth.
- hci_pkg also gains the state enum tti_rx_packer_state_e.
- Single module with one FSM plus a byte-lane datapath. No sub-module is warranted.

## Test plan
- Bytes 0x11,0x22,0x33,0x44,0x55 then end beat (err = 0), both readies held high:
  - words 0x44332211, then 0x00000055;
  - then descriptor 0x00000005.
- End beat only, in_err_i = 1 → no data word; descriptor 0x00010000.
- 8 bytes 0x01..0x08 with rx_data_ready_i low for 10 cycles after the first word:
  - in_ready_o stays 0 and rx_data_o holds 0x04030201;
  - the second word is 0x08070605;
  - descriptor length is 8 and appears only after both pops.
- 65537 bytes then end beat → descriptor 0x0002FFFF (length saturated, overflow flag set), 16385 data words.
- Assert rst_ni low while in FLUSH with valid high → all outputs return to reset values asynchronously.
  - After release, a 1-byte transfer of 0xAB gives word 0x000000AB and descriptor 0x00000001.
- rx_desc_ready_i low for 5 cycles in DESC:
  - rx_desc_o stays stable and in_ready_o stays 0;
  - after the pop, the next transfer's length restarts from 0.
